pc_select_ras: RTL and testbench

- Parametrised next-PC selection stage for the Y86 pipeline.
- Selects the next PC from val_P, val_C or val_M according to the instruction code and branch condition, then registers it.
- Adds a circular return-address stack (RAS): ICALL pushes its return address, IRET pops the stack and checks the predicted return address against val_M.
- Also adds a stall hold, a flush/redirect path with its own target, and sticky overflow/underflow status for the performance counters.

---
 rtl/pc_select_ras.sv | 134 +++++++++++++
 tb/tb_pc_select_ras.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_select_ras.sv
// Next-PC selection for the Y86 pipeline with a circular return-address stack.
// Covers call/return prediction checking, stall hold, flush redirect and sticky RAS status.
module pc_select_ras #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       CODE_W    = 4,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic                               valid,
    input  logic                               stall,
    input  logic                               flush,
    input  logic [ADDR_W-1:0]                  flush_pc,
    input  logic [CODE_W-1:0]                  code,
    input  logic                               cnd,
    input  logic [ADDR_W-1:0]                  val_P,
    input  logic [ADDR_W-1:0]                  val_C,
    input  logic [ADDR_W-1:0]                  val_M,
    output logic [ADDR_W-1:0]                  val_P_reg,
    output logic                               pc_upd,
    output logic                               ret_hit,
    output logic                               ret_miss,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_ovf,
    output logic                               ras_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [CODE_W-1:0] I_JXX  = CODE_W'(7);
    localparam logic [CODE_W-1:0] I_CALL = CODE_W'(8);
    localparam logic [CODE_W-1:0] I_RET  = CODE_W'(9);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_upd_q, pc_upd_d;
    logic              ret_hit_q, ret_hit_d;
    logic              ret_miss_q, ret_miss_d;
    logic [PTR_W-1:0]  tp_q, tp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_en;
    logic [ADDR_W-1:0] ras_top;

    assign ras_top = ras_mem[tp_q];

    always_comb begin
        pc_d       = pc_q;
        pc_upd_d   = 1'b0;
        ret_hit_d  = 1'b0;
        ret_miss_d = 1'b0;
        tp_d       = tp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push_en    = 1'b0;

        if (flush) begin
            pc_d     = flush_pc;
            pc_upd_d = 1'b1;
            tp_d     = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (!stall && valid) begin
            pc_upd_d = 1'b1;
            unique case (code)
                I_CALL: begin
                    pc_d    = val_C;
                    push_en = 1'b1;
                    tp_d    = tp_q + PTR_W'(1);
                    // A full stack keeps its count; the push lands on the oldest slot.
                    if (cnt_q < CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
                    else                           ovf_d = 1'b1;
                end
                I_RET: begin
                    pc_d = val_M;
                    if (cnt_q != '0) begin
                        ret_hit_d  = (ras_top == val_M);
                        ret_miss_d = (ras_top != val_M);
                        tp_d       = tp_q - PTR_W'(1);
                        cnt_d      = cnt_q - CNT_W'(1);
                    end else begin
                        ret_miss_d = 1'b1;
                        unf_d      = 1'b1;
                    end
                end
                I_JXX:   pc_d = cnd ? val_C : val_P;
                default: pc_d = val_P;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_upd_q   <= 1'b0;
            ret_hit_q  <= 1'b0;
            ret_miss_q <= 1'b0;
            tp_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_upd_q   <= pc_upd_d;
            ret_hit_q  <= ret_hit_d;
            ret_miss_q <= ret_miss_d;
            tp_q       <= tp_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // NOTE: the stack array has no reset; entries above ras_count are never read as valid.
    always_ff @(posedge sys_clk) begin
        if (push_en) ras_mem[tp_d] <= val_P;
    end

    assign val_P_reg = pc_q;
    assign pc_upd    = pc_upd_q;
    assign ret_hit   = ret_hit_q;
    assign ret_miss  = ret_miss_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_select_ras.sv
// Self-checking bench for pc_select_ras: directed scenarios plus randomized traffic
// compared against a queue-based model of the PC selection and return-address stack.
module tb_pc_select_ras;

    localparam int DEPTH = 8;
    localparam logic [3:0] C_JXX  = 4'h7;
    localparam logic [3:0] C_CALL = 4'h8;
    localparam logic [3:0] C_RET  = 4'h9;

    logic        sys_clk;
    logic        rst;
    logic        valid, stall, flush, cnd;
    logic [63:0] flush_pc, val_P, val_C, val_M;
    logic [3:0]  code;
    logic [63:0] val_P_reg;
    logic        pc_upd, ret_hit, ret_miss, ras_ovf, ras_unf;
    logic [3:0]  ras_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic        m_upd, m_hit, m_miss, m_ovf, m_unf;
    logic [63:0] m_ras[$];

    pc_select_ras #(.ADDR_W(64), .CODE_W(4), .RAS_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .valid    (valid),
        .stall    (stall),
        .flush    (flush),
        .flush_pc (flush_pc),
        .code     (code),
        .cnd      (cnd),
        .val_P    (val_P),
        .val_C    (val_C),
        .val_M    (val_M),
        .val_P_reg(val_P_reg),
        .pc_upd   (pc_upd),
        .ret_hit  (ret_hit),
        .ret_miss (ret_miss),
        .ras_count(ras_count),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_upd = 0; m_hit = 0; m_miss = 0; m_ovf = 0; m_unf = 0;
        m_ras.delete();
    endtask

    task automatic model_apply();
        logic [63:0] top;
        m_upd = 0; m_hit = 0; m_miss = 0;
        if (flush) begin
            m_pc = flush_pc; m_upd = 1; m_ovf = 0; m_unf = 0;
            m_ras.delete();
        end else if (!stall && valid) begin
            m_upd = 1;
            if (code == C_CALL) begin
                m_pc = val_C;
                m_ras.push_back(val_P);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
            end else if (code == C_RET) begin
                m_pc = val_M;
                if (m_ras.size() > 0) begin
                    top    = m_ras.pop_back();
                    m_hit  = (top == val_M);
                    m_miss = (top != val_M);
                end else begin
                    m_miss = 1; m_unf = 1;
                end
            end else if (code == C_JXX) begin
                m_pc = cnd ? val_C : val_P;
            end else begin
                m_pc = val_P;
            end
        end
    endtask

    task automatic check_all();
        check("val_P_reg", val_P_reg, m_pc);
        check("pc_upd", 64'(pc_upd), 64'(m_upd));
        check("ret_hit", 64'(ret_hit), 64'(m_hit));
        check("ret_miss", 64'(ret_miss), 64'(m_miss));
        check("ras_count", 64'(ras_count), 64'(m_ras.size()));
        check("ras_ovf", 64'(ras_ovf), 64'(m_ovf));
        check("ras_unf", 64'(ras_unf), 64'(m_unf));
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        model_apply();
        check_all();
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] c,
                         input logic cn, input logic [63:0] p, input logic [63:0] cc,
                         input logic [63:0] m, input logic [63:0] fp);
        valid = v; stall = s; flush = f; code = c; cnd = cn;
        val_P = p; val_C = cc; val_M = m; flush_pc = fp;
        step();
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge sys_clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        valid = 0; stall = 0; flush = 0; cnd = 0; code = 4'h0;
        flush_pc = '0; val_P = '0; val_C = '0; val_M = '0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_all();
        rst = 1'b0;

        // Disturb state, then reset in the middle of a cycle
        drive(1, 0, 0, C_CALL, 0, 64'h55, 64'h77, 0, 0);
        async_reset();
        repeat (3) drive(0, 0, 0, C_CALL, 1, 64'h9, 64'hA, 64'hB, 64'hC);

        // Call/return pair with a matching return address
        drive(1, 0, 0, C_CALL, 0, 64'h20, 64'h100, 0, 0);
        check("call_pc", val_P_reg, 64'h100);
        drive(1, 0, 0, C_RET, 0, 0, 0, 64'h20, 0);
        check("ret_pc", val_P_reg, 64'h20);
        check("ret_hit_pair", 64'(ret_hit), 64'd1);

        // Return mismatch
        drive(1, 0, 0, C_CALL, 0, 64'h40, 64'h200, 0, 0);
        drive(1, 0, 0, C_RET, 0, 0, 0, 64'h44, 0);
        check("ret_miss_pair", 64'(ret_miss), 64'd1);

        // Overflow and wrap-around, then underflow
        for (int i = 0; i < 10; i++) drive(1, 0, 0, C_CALL, 0, 64'h10 + 64'(i), 64'h500, 0, 0);
        check("ovf_after_10", 64'(ras_ovf), 64'd1);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, C_RET, 0, 0, 0, 64'h19 - 64'(i), 0);
        check("wrap_last_hit", 64'(ret_hit), 64'd1);
        drive(1, 0, 0, C_RET, 0, 0, 0, 64'h11, 0);
        check("unf_9th_ret", 64'(ras_unf), 64'd1);

        // Conditional jumps and stall
        drive(1, 0, 0, C_JXX, 1, 64'h304, 64'h300, 0, 0);
        check("jxx_taken", val_P_reg, 64'h300);
        drive(1, 0, 0, C_JXX, 0, 64'h308, 64'h300, 0, 0);
        check("jxx_not_taken", val_P_reg, 64'h308);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, C_CALL, 0, 64'h600 + 64'(i), 64'h700, 0, 0);
        drive(1, 1, 0, C_CALL, 0, 64'h999, 64'h888, 0, 0);
        check("stall_count", 64'(ras_count), 64'd3);

        // Flush beats stall and valid
        drive(1, 1, 1, C_CALL, 0, 64'h999, 64'h888, 0, 64'h800);
        check("flush_pc", val_P_reg, 64'h800);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] c;
            logic [63:0] m;
            case ($urandom_range(0, 9))
                0, 1, 2: c = C_CALL;
                3, 4, 5: c = C_RET;
                6, 7:    c = C_JXX;
                default: c = 4'($urandom);
            endcase
            m = {$urandom, $urandom};
            if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) m = m_ras[$];
            if (i == 1500) async_reset();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, c, 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, m, {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
